// File: rtl/y86_seq_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : y86_seq_controller_if
// Description : Bundle between the Y86 sequencer and the datapath stages:
//               fault/handshake inputs, stage enables, PC, status, counters.
//               The step signal exists only when SEQ_STEP_MODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface y86_seq_controller_if #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
);
    // datapath -> sequencer
    logic              start;
    logic [3:0]        icode;
    logic              halt;
    logic              invalid_instr;
    logic              fetch_mem_error;
    logic              data_mem_error;
    logic              mem_ack;
    logic [ADDR_W-1:0] pc_next;
`ifdef SEQ_STEP_MODE_EN
    logic              step;
`endif
    // sequencer -> datapath
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              decode_en;
    logic              exec_en;
    logic              mem_en;
    logic              wb_en;
    logic              pc_en;
    logic              mem_req;
    logic [3:0]        stat;
    logic              running;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  cycle_count;

    // Sequencer side: owns the enables, PC and memory request.
    modport master (
`ifdef SEQ_STEP_MODE_EN
        input  step,
`endif
        input  start, icode, halt, invalid_instr, fetch_mem_error,
               data_mem_error, mem_ack, pc_next,
        output pc, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en,
               mem_req, stat, running, instr_count, cycle_count
    );

    // Datapath side.
    modport slave (
`ifdef SEQ_STEP_MODE_EN
        output step,
`endif
        output start, icode, halt, invalid_instr, fetch_mem_error,
               data_mem_error, mem_ack, pc_next,
        input  pc, fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en,
               mem_req, stat, running, instr_count, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/y86_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : y86_seq_controller
// Description : Multi-cycle stage sequencer for the sequential Y86 core.
//               Walks FETCH/DECODE/EXEC/MEM/WB/PCUPD, owns the PC, the
//               one-hot status code and the data-memory request handshake.
//               Optional single-step mode: define SEQ_STEP_MODE_EN to add
//               the step input and a PAUSE state after every PC update.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_seq_controller #(
    parameter int                ADDR_W       = 64,
    parameter logic [ADDR_W-1:0] PC_RESET     = '0,
    parameter int                MEM_WAIT_MAX = 15,
    parameter int                CNT_W        = 32
) (
    input  wire logic            clk,
    input  wire logic            rst,
    y86_seq_controller_if.master bus
);

    // Wait counter only has to reach MEM_WAIT_MAX-1.
    localparam int                WAIT_W      = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    localparam logic [3:0] c_STAT_AOK = 4'b0001;
    localparam logic [3:0] c_STAT_HLT = 4'b0010;
    localparam logic [3:0] c_STAT_ADR = 4'b0100;
    localparam logic [3:0] c_STAT_INS = 4'b1000;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC   = 4'd3;
    localparam logic [3:0] S_MEM    = 4'd4;
    localparam logic [3:0] S_WB     = 4'd5;
    localparam logic [3:0] S_PCUPD  = 4'd6;
    localparam logic [3:0] S_STOP   = 4'd7;
`ifdef SEQ_STEP_MODE_EN
    localparam logic [3:0] S_PAUSE  = 4'd8;
`endif

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_stat;
    logic [CNT_W-1:0]  r_instr_count;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_mem_op;

    logic              w_icode_mem;
    logic              w_fetch_fault;
    logic [3:0]        w_fetch_stat;
    logic              w_mem_done;
    logic              w_mem_fail;
    logic              w_count_cycle;
    logic              w_fetch_en;
    logic              w_decode_en;
    logic              w_exec_en;
    logic              w_mem_en;
    logic              w_wb_en;
    logic              w_pc_en;
    logic              w_mem_req;
    logic              w_running;

    // Classify icodes that touch data memory (rmmov, mrmov, call, ret, push, pop).
    always_comb begin
        case (bus.icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_icode_mem = 1'b1;
            default:                            w_icode_mem = 1'b0;
        endcase
    end

    // Fetch fault priority: address error, then illegal instruction, then halt.
    always_comb begin
        w_fetch_fault = 1'b1;
        w_fetch_stat  = c_STAT_AOK;
        if (bus.fetch_mem_error) begin
            w_fetch_stat = c_STAT_ADR;
        end else if (bus.invalid_instr) begin
            w_fetch_stat = c_STAT_INS;
        end else if (bus.halt) begin
            w_fetch_stat = c_STAT_HLT;
        end else begin
            w_fetch_fault = 1'b0;
        end
    end

    // Memory stage outcome; an ack in the last allowed cycle still completes.
    always_comb begin
        w_mem_done = !r_mem_op || (bus.mem_ack && !bus.data_mem_error);
        w_mem_fail = r_mem_op && (bus.mem_ack ? bus.data_mem_error : (r_wait == c_WAIT_LAST));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = w_fetch_fault ? S_STOP : S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_MEM;
            S_MEM: begin
                if (w_mem_done) begin
                    w_state_nxt = S_WB;
                end else if (w_mem_fail) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_WB:     w_state_nxt = S_PCUPD;
`ifdef SEQ_STEP_MODE_EN
            S_PCUPD:  w_state_nxt = S_PAUSE;
            S_PAUSE:  if (bus.step) w_state_nxt = S_FETCH;
`else
            S_PCUPD:  w_state_nxt = S_FETCH;
`endif
            S_STOP:   w_state_nxt = S_STOP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        w_fetch_en    = 1'b0;
        w_decode_en   = 1'b0;
        w_exec_en     = 1'b0;
        w_mem_en      = 1'b0;
        w_wb_en       = 1'b0;
        w_pc_en       = 1'b0;
        w_mem_req     = 1'b0;
        case (r_state)
            S_FETCH:  w_fetch_en  = 1'b1;
            S_DECODE: w_decode_en = 1'b1;
            S_EXEC:   w_exec_en   = 1'b1;
            S_MEM: begin
                w_mem_en  = 1'b1;
                w_mem_req = r_mem_op;
            end
            S_WB:     w_wb_en     = 1'b1;
            S_PCUPD:  w_pc_en     = 1'b1;
            default: ;
        endcase
        w_running     = (r_state != S_IDLE) && (r_state != S_STOP);
`ifdef SEQ_STEP_MODE_EN
        w_count_cycle = w_running && (r_state != S_PAUSE);
`else
        w_count_cycle = w_running;
`endif
    end

    // PC, status, saturating counters and memory wait tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= PC_RESET;
            r_stat        <= c_STAT_AOK;
            r_instr_count <= '0;
            r_cycle_count <= '0;
            r_wait        <= '0;
            r_mem_op      <= 1'b0;
        end else begin
            if (w_count_cycle && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (w_fetch_fault) begin
                        r_stat <= w_fetch_stat;
                    end
                end
                S_EXEC: begin
                    // Latch the memory class so mem_req stays a pure state decode.
                    r_mem_op <= w_icode_mem;
                    r_wait   <= '0;
                end
                S_MEM: begin
                    if (w_mem_fail) begin
                        r_stat <= c_STAT_ADR;
                    end else if (r_mem_op && !bus.mem_ack) begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_PCUPD: begin
                    r_pc <= bus.pc_next;
                    if (r_instr_count != '1) begin
                        r_instr_count <= r_instr_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.stat        = r_stat;
    assign bus.instr_count = r_instr_count;
    assign bus.cycle_count = r_cycle_count;
    assign bus.fetch_en    = w_fetch_en;
    assign bus.decode_en   = w_decode_en;
    assign bus.exec_en     = w_exec_en;
    assign bus.mem_en      = w_mem_en;
    assign bus.wb_en       = w_wb_en;
    assign bus.pc_en       = w_pc_en;
    assign bus.mem_req     = w_mem_req;
    assign bus.running     = w_running;

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_y86_seq_controller
// Description : Self-checking bench for y86_seq_controller. Instruction-level
//               model predicts each cycle's enables, request, PC, status and
//               counters; a negedge process compares the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_seq_controller;

    localparam int                ADDR_W       = 32;
    localparam int                CNT_W        = 6;
    localparam int                MEM_WAIT_MAX = 4;
    localparam logic [ADDR_W-1:0] PC_RST       = '0;
    localparam int                CMAX         = (1 << CNT_W) - 1;

    localparam logic [5:0] E_F = 6'b100000;
    localparam logic [5:0] E_D = 6'b010000;
    localparam logic [5:0] E_E = 6'b001000;
    localparam logic [5:0] E_M = 6'b000100;
    localparam logic [5:0] E_W = 6'b000010;
    localparam logic [5:0] E_P = 6'b000001;
    localparam logic [5:0] E_0 = 6'b000000;

    localparam logic [3:0] AOK = 4'b0001;
    localparam logic [3:0] HLT = 4'b0010;
    localparam logic [3:0] ADR = 4'b0100;
    localparam logic [3:0] INS = 4'b1000;

    typedef struct packed {
        logic [5:0]        en;
        logic              mreq;
        logic              run;
        logic [ADDR_W-1:0] pc;
        logic [3:0]        stat;
        logic [CNT_W-1:0]  icnt;
        logic [CNT_W-1:0]  ccnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    y86_seq_controller_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    y86_seq_controller #(
        .ADDR_W       (ADDR_W),
        .PC_RESET     (PC_RST),
        .MEM_WAIT_MAX (MEM_WAIT_MAX),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t e_cur;
    exp_t a_cur;
    int   checks   = 0;
    int   failures = 0;
    int   n_req    = 0;

    // Model state
    logic [ADDR_W-1:0] m_pc;
    logic [3:0]        m_stat;
    int                m_icnt;
    int                m_ccnt;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_pc   = PC_RST;
        m_stat = AOK;
        m_icnt = 0;
        m_ccnt = 0;
    endfunction

    // Per-cycle comparison against the model's prediction.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) n_req++;
        if (q.size() != 0) begin
            e_cur      = q.pop_front();
            a_cur.en   = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en, bus.pc_en};
            a_cur.mreq = bus.mem_req;
            a_cur.run  = bus.running;
            a_cur.pc   = bus.pc;
            a_cur.stat = bus.stat;
            a_cur.icnt = bus.instr_count;
            a_cur.ccnt = bus.cycle_count;
            checks++;
            if (a_cur !== e_cur) begin
                failures++;
                $display("FAIL cycle@%0t got en=%b req=%b run=%b pc=%h stat=%b ic=%0d cc=%0d want en=%b req=%b run=%b pc=%h stat=%b ic=%0d cc=%0d",
                         $time, a_cur.en, a_cur.mreq, a_cur.run, a_cur.pc, a_cur.stat, a_cur.icnt, a_cur.ccnt,
                         e_cur.en, e_cur.mreq, e_cur.run, e_cur.pc, e_cur.stat, e_cur.icnt, e_cur.ccnt);
            end
        end
    end

    // Record the expected outputs of the current cycle, then advance one clock.
    task automatic cyc(input logic [5:0] en, input bit mreq, input bit run, input bit cnt);
        exp_t e;
        e.en   = en;
        e.mreq = mreq;
        e.run  = run;
        e.pc   = m_pc;
        e.stat = m_stat;
        e.icnt = CNT_W'(m_icnt);
        e.ccnt = CNT_W'(m_ccnt);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (run && cnt) m_ccnt = sat(m_ccnt + 1);
    endtask

    // Randomise every input the current state should ignore.
    task automatic noise();
        bus.start           = 1'($urandom);
        bus.halt            = 1'($urandom);
        bus.invalid_instr   = 1'($urandom);
        bus.fetch_mem_error = 1'($urandom);
        bus.data_mem_error  = 1'($urandom);
        bus.mem_ack         = 1'($urandom);
        bus.pc_next         = ADDR_W'($urandom);
`ifdef SEQ_STEP_MODE_EN
        bus.step            = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_seq(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            noise();
            bus.start = 1'b0;
            cyc(E_0, 1'b0, 1'b0, 1'b1);
        end
        noise();
        bus.start = 1'b1;
        cyc(E_0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic stop_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            cyc(E_0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // One instruction from FETCH. flt = {fetch_mem_error, invalid_instr, halt};
    // k = MEM cycle carrying the ack (beyond MEM_WAIT_MAX means never);
    // rst_mem = MEM cycle in which rst is pulsed (0 = none).
    task automatic run_instr(input logic [3:0] ic, input logic [2:0] flt, input int k, input bit err,
                             input logic [ADDR_W-1:0] nxt, input int rst_mem, output bit stopped);
        bit is_mem;
        stopped = 1'b0;
        is_mem  = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
        noise();
        bus.icode = ic;
        {bus.fetch_mem_error, bus.invalid_instr, bus.halt} = flt;
        cyc(E_F, 1'b0, 1'b1, 1'b1);
        if (flt != 3'b000) begin
            m_stat  = flt[2] ? ADR : (flt[1] ? INS : HLT);
            stopped = 1'b1;
            return;
        end
        noise(); cyc(E_D, 1'b0, 1'b1, 1'b1);
        noise(); cyc(E_E, 1'b0, 1'b1, 1'b1);
        if (is_mem) begin
            for (int j = 1; j <= MEM_WAIT_MAX; j++) begin
                noise();
                bus.mem_ack = (j == k);
                if (j == k) bus.data_mem_error = err;
                if (j == rst_mem) rst = 1'b1;
                cyc(E_M, 1'b1, 1'b1, 1'b1);
                if (j == rst_mem) begin
                    rst     = 1'b0;
                    stopped = 1'b1;
                    return;
                end
                if (j == k) begin
                    if (err) begin
                        m_stat  = ADR;
                        stopped = 1'b1;
                        return;
                    end
                    break;
                end
                if (j == MEM_WAIT_MAX) begin
                    m_stat  = ADR;
                    stopped = 1'b1;
                    return;
                end
            end
        end else begin
            noise(); cyc(E_M, 1'b0, 1'b1, 1'b1);
        end
        noise(); cyc(E_W, 1'b0, 1'b1, 1'b1);
        noise();
        bus.pc_next = nxt;
        cyc(E_P, 1'b0, 1'b1, 1'b1);
        m_pc   = nxt;
        m_icnt = sat(m_icnt + 1);
`ifdef SEQ_STEP_MODE_EN
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            noise();
            cyc(E_0, 1'b0, 1'b1, 1'b0);
        end
        noise();
        bus.step = 1'b1;
        cyc(E_0, 1'b0, 1'b1, 1'b0);
        bus.step = 1'b0;
`endif
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit               stopped;
        logic [3:0]       ic;
        logic [2:0]       flt;
        int               k;
        bit               err;
        int               n;

        rst       = 1'b1;
        bus.icode = 4'h0;
        noise();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_pc",   64'(bus.pc), 64'h0);
        chk("rst_stat", 64'(bus.stat), 64'h1);
        chk("rst_cnt",  64'({bus.instr_count, bus.cycle_count}), 64'h0);
        chk("rst_outs", 64'({bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_en, bus.wb_en,
                             bus.pc_en, bus.mem_req, bus.running}), 64'h0);

        // Plain ALU instruction: six one-cycle stages, pc 0 -> 2
        start_seq(1);
        run_instr(4'h6, 3'b000, 0, 1'b0, m_pc + 2, 0, stopped);
        chk("t1_pc",   64'(bus.pc), 64'h2);
        chk("t1_icnt", 64'(bus.instr_count), 64'd1);
        chk("t1_ccnt", 64'(bus.cycle_count), 64'd6);

        // mrmovq acked in third MEM cycle: three request cycles, eight cycles total
        n_req = 0;
        run_instr(4'h5, 3'b000, 3, 1'b0, 32'h10, 0, stopped);
        chk("t2_nreq", 64'(n_req), 64'd3);
        chk("t2_ccnt", 64'(bus.cycle_count), 64'd14);
        chk("t2_stat", 64'(bus.stat), 64'h1);
        chk("t2_pc",   64'(bus.pc), 64'h10);

        // Unacknowledged request times out after MEM_WAIT_MAX cycles
        do_reset();
        start_seq(0);
        n_req = 0;
        run_instr(4'hA, 3'b000, MEM_WAIT_MAX + 1, 1'b0, 32'h99, 0, stopped);
        stop_cycles(3);
        chk("t3_nreq", 64'(n_req), 64'd4);
        chk("t3_stat", 64'(bus.stat), 64'h4);
        chk("t3_run",  64'(bus.running), 64'h0);
        chk("t3_pc",   64'(bus.pc), 64'h0);
        chk("t3_icnt", 64'(bus.instr_count), 64'h0);

        // Halt in first fetch; start afterwards is ignored
        do_reset();
        start_seq(0);
        run_instr(4'h0, 3'b001, 0, 1'b0, 32'h4, 0, stopped);
        for (int i = 0; i < 3; i++) begin
            noise();
            bus.start = 1'b1;
            cyc(E_0, 1'b0, 1'b0, 1'b1);
        end
        chk("t4_stat", 64'(bus.stat), 64'h2);
        chk("t4_pc",   64'(bus.pc), 64'h0);

        // Address error beats invalid instruction
        do_reset();
        start_seq(0);
        run_instr(4'h1, 3'b110, 0, 1'b0, 32'h4, 0, stopped);
        stop_cycles(2);
        chk("t5_stat", 64'(bus.stat), 64'h4);

        // Reset during second MEM cycle of mrmovq, then a clean run
        do_reset();
        start_seq(0);
        run_instr(4'h6, 3'b000, 0, 1'b0, 32'h40, 0, stopped);
        run_instr(4'h5, 3'b000, MEM_WAIT_MAX + 1, 1'b0, 32'h0, 2, stopped);
        chk("t6_stat", 64'(bus.stat), 64'h1);
        chk("t6_pc",   64'(bus.pc), 64'h0);
        chk("t6_cnt",  64'({bus.instr_count, bus.cycle_count}), 64'h0);
        chk("t6_req",  64'(bus.mem_req), 64'h0);
        start_seq(1);
        run_instr(4'h5, 3'b000, 1, 1'b0, 32'h20, 0, stopped);
        chk("t6_pc2",  64'(bus.pc), 64'h20);
        chk("t6_ic2",  64'(bus.instr_count), 64'd1);

        // Random episodes; the first is long and fault-free to saturate counters
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            start_seq(int'($urandom_range(0, 2)));
            n = (ep == 0) ? 80 : int'($urandom_range(5, 25));
            stopped = 1'b0;
            for (int i = 0; i < n && !stopped; i++) begin
                ic  = 4'($urandom);
                flt = (ep != 0 && $urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                k   = (ep == 0) ? int'($urandom_range(1, MEM_WAIT_MAX)) : int'($urandom_range(1, MEM_WAIT_MAX + 1));
                err = (ep != 0) && ($urandom_range(0, 7) == 0);
                run_instr(ic, flt, k, err, ADDR_W'($urandom), 0, stopped);
            end
            if (stopped) stop_cycles(3);
            if (ep == 0) begin
                chk("sat_icnt", 64'(bus.instr_count), 64'd63);
                chk("sat_ccnt", 64'(bus.cycle_count), 64'd63);
            end
        end

        @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
